// File: rtl/vend_fsm_param.sv
// Parametrised vending controller: accumulates 50c credit, dispenses at PRICE,
// refunds change one coin per cycle, with over-limit rejection and idle timeout.
module vend_fsm_param #(
    parameter int unsigned PRICE       = 2,
    parameter int unsigned MAX_CREDIT  = 8,
    parameter int unsigned CREDIT_W    = 4,
    parameter int unsigned VEND_CYCLES = 3,
    parameter int unsigned TIMEOUT     = 16,
    parameter int unsigned SALES_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fifty,
    input  logic                dollar,
    input  logic                cancel,
    output logic [1:0]          st,
    output logic [CREDIT_W-1:0] credit,
    output logic                insert_coin,
    output logic                dispense,
    output logic                money_return,
    output logic                coin_reject,
    output logic [SALES_W-1:0]  sales
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StCredit = 2'd1,
        StVend   = 2'd2,
        StReturn = 2'd3
    } state_e;

    localparam int unsigned CW1  = CREDIT_W + 1;
    localparam int unsigned VtW  = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;
    localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e               st_q, st_d;
    logic [CREDIT_W-1:0]  credit_q, credit_d;
    logic [VtW-1:0]       vend_q, vend_d;
    logic [TmoW-1:0]      tmo_q, tmo_d;
    logic [SALES_W-1:0]   sales_q, sales_d;
    logic                 rej_q, rej_d;

    logic [CW1-1:0]       add, sum, total;
    logic                 coin, accept, tmo_hit;

    always_comb begin
        add     = CW1'(fifty) + (CW1'(dollar) << 1);
        sum     = CW1'(credit_q) + add;
        coin    = fifty | dollar;
        accept  = coin && (sum <= CW1'(MAX_CREDIT));
        total   = accept ? sum : CW1'(credit_q);
        tmo_hit = (TIMEOUT > 0) && (tmo_q == TmoW'(TIMEOUT - 1));
    end

    always_comb begin
        st_d     = st_q;
        credit_d = credit_q;
        vend_d   = vend_q;
        tmo_d    = '0;
        sales_d  = sales_q;
        rej_d    = 1'b0;
        case (st_q)
            StVend: begin
                rej_d = coin;
                if (vend_q == '0) begin
                    sales_d = sales_q + SALES_W'(1);
                    st_d    = (credit_q != '0) ? StReturn : StIdle;
                end else begin
                    vend_d = vend_q - VtW'(1);
                end
            end
            StReturn: begin
                rej_d    = coin;
                credit_d = credit_q - CREDIT_W'(1);
                if (credit_q <= CREDIT_W'(1)) begin
                    st_d     = StIdle;
                    credit_d = '0;
                end
            end
            // IDLE and CREDIT share the coin/cancel decision logic
            default: begin
                rej_d = coin && !accept;
                if (cancel) begin
                    st_d     = (total != '0) ? StReturn : StIdle;
                    credit_d = total[CREDIT_W-1:0];
                end else if (total >= CW1'(PRICE)) begin
                    st_d     = StVend;
                    credit_d = CREDIT_W'(total - CW1'(PRICE));
                    vend_d   = VtW'(VEND_CYCLES - 1);
                end else if (total != '0) begin
                    credit_d = total[CREDIT_W-1:0];
                    if (st_q == StCredit && !accept && tmo_hit) begin
                        st_d = StReturn;
                    end else begin
                        st_d = StCredit;
                        if (st_q == StCredit && !accept) begin
                            tmo_d = tmo_q + TmoW'(1);
                        end
                    end
                end else begin
                    st_d     = StIdle;
                    credit_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q     <= StIdle;
            credit_q <= '0;
            vend_q   <= '0;
            tmo_q    <= '0;
            sales_q  <= '0;
            rej_q    <= 1'b0;
        end else begin
            st_q     <= st_d;
            credit_q <= credit_d;
            vend_q   <= vend_d;
            tmo_q    <= tmo_d;
            sales_q  <= sales_d;
            rej_q    <= rej_d;
        end
    end

    assign st           = st_q;
    assign credit       = credit_q;
    assign sales        = sales_q;
    assign coin_reject  = rej_q;
    assign insert_coin  = (st_q == StIdle) || (st_q == StCredit);
    assign dispense     = (st_q == StVend);
    assign money_return = (st_q == StReturn);

endmodule
